bicubic_mac: RTL
================

BICUBIC_MAC -- requirements
Module: bicubic_mac

Interface
REQ-001 The module SHALL have parameter A_W, default 18: width of pixel operand s_a.
REQ-002 The module SHALL have parameter B_W, default 8: width of coefficient operand s_b.
REQ-003 The module SHALL have parameter TAPS, default 4: products summed per result, >=2.
REQ-004 The module SHALL have parameter MUL_LAT, default 2: register stages in the multiplier, >=1.
REQ-005 The module SHALL have parameter FRAC, default 6: fractional bits removed by rounding, >=0.
REQ-006 The module SHALL have parameter OUT_W, default 8: result width.
REQ-007 The module SHALL have parameters A_SIGNED/B_SIGNED/OUT_SIGNED, defaults 0/1/0: operand and result signedness.
REQ-008 The module SHALL have port aclk, input, 1: single clock; all logic on rising edge.
REQ-009 The module SHALL have port areset, input, 1: asynchronous, active-high reset.
REQ-010 The module SHALL have port s_valid, input, 1: input beat valid.
REQ-011 The module SHALL have port s_ready, output, 1: input beat accepted when s_valid&s_ready.
REQ-012 The module SHALL have port s_a, input, A_W: pixel sample.
REQ-013 The module SHALL have port s_b, input, B_W: filter coefficient.
REQ-014 The module SHALL have port m_valid, output, 1: result valid.
REQ-015 The module SHALL have port m_ready, input, 1: downstream accepts when m_valid&m_ready.
REQ-016 The module SHALL have port m_data, output, OUT_W: rounded, saturated result.
REQ-017 The module SHALL have port m_sat, output, 1: m_data was clamped; qualified by m_valid.

Function
REQ-018 Product width P_W=A_W+B_W and accumulator width ACC_W=P_W+clog2(TAPS) SHALL be used, with sign extension per A_SIGNED/B_SIGNED, so no overflow occurs.
REQ-019 A global enable en=!m_valid|m_ready SHALL drive s_ready=en; multiplier stages, tap counter and accumulator advance only when en.
REQ-020 Each accepted beat SHALL enter the multiplier with a valid bit that follows it through MUL_LAT stages; bubbles carry valid=0 and do not affect the accumulator.
REQ-021 The tap counter (0..TAPS-1) SHALL increment on each valid product leaving the multiplier and wrap to 0 after TAPS-1.
REQ-022 A product at tap 0 SHALL load the accumulator; other taps add to it.
REQ-023 On tap TAPS-1, sum=acc+product SHALL be rounded (add 2^(FRAC-1) when FRAC>0, arithmetic shift right FRAC) and clamped to OUT_W range per OUT_SIGNED, loading m_data, m_sat and m_valid=1 in the same edge.
REQ-024 Latency SHALL be MUL_LAT+1 cycles from acceptance of the last tap to m_valid, with no stall.
REQ-025 Throughput SHALL be one beat per cycle with m_ready=1; a result handshake and a new result load in the same cycle SHALL both take effect.
REQ-026 When en=1 and no result completes, m_valid SHALL clear; while m_valid&!m_ready, m_data/m_sat SHALL hold stable and no beat is lost or duplicated.

Reset
REQ-027 areset SHALL asynchronously clear m_valid, m_data, m_sat, all pipeline valid bits, tap counter and accumulator to 0; s_ready SHALL be 1 while in reset and after release.
REQ-028 areset mid-group SHALL discard partial taps; the next accepted beat is tap 0.

Structure
REQ-029 Package bicubic_pkg SHALL hold default widths (A_W, B_W, TAPS, FRAC, OUT_W) and a round-and-saturate function shared with other bicubic stages.
REQ-030 The multiplier SHALL be a sub-module mul_pipe (MUL_LAT stages, enable, valid pass-through, signedness parameters).

Verification
REQ-031 a=100 x4, b=16 x4 -> m_data=100, m_sat=0, m_valid exactly MUL_LAT+1 cycles after 4th beat.
REQ-032 a=255 x4, b={0,80,0,0} -> m_data=255, m_sat=1; a=255 x4, b={0,0,-64,0} -> m_data=0, m_sat=1.
REQ-033 Result pending with m_ready=0 for 10 cycles -> s_ready=0, m_data stable; 3 groups then complete in order, no loss.
REQ-034 Two taps accepted, areset pulsed -> all outputs 0; next 4 beats (a=50, b=16) -> m_data=50.
REQ-035 8 back-to-back beats, m_ready=1 -> exactly 2 results, 4 cycles apart, s_ready never low.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared defaults and helpers for the bicubic filter stages.
// Holds the round-and-saturate used when narrowing accumulators.
package bicubic_pkg;

  localparam int DEF_A_W     = 18;
  localparam int DEF_B_W     = 8;
  localparam int DEF_TAPS    = 4;
  localparam int DEF_MUL_LAT = 2;
  localparam int DEF_FRAC    = 6;
  localparam int DEF_OUT_W   = 8;

  typedef struct packed {
    logic [63:0] data;
    logic        sat;
  } rs_t;

  // Round half-up, drop frac bits, clamp to out_w (signed or unsigned).
  // sum must already be sign/zero extended to 64 bits; out_w <= 62.
  function automatic rs_t round_sat(
    input logic signed [63:0] sum,
    input int unsigned        frac,
    input int unsigned        out_w,
    input logic               out_signed
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t                res;
    r = sum;
    if (frac > 0) begin
      r = r + (64'sd1 <<< (frac - 1));
    end
    r = r >>> frac;
    if (out_signed) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end else begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end
    res.sat  = 1'b0;
    res.data = r;
    if (r > hi) begin
      res.data = hi;
      res.sat  = 1'b1;
    end else if (r < lo) begin
      res.data = lo;
      res.sat  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bicubic_mac_mul_pipe.sv
// Pipelined multiplier with a valid bit riding alongside each product.
// All stages advance together under a shared enable.
module mul_pipe #(
  parameter int A_W      = 18,
  parameter int B_W      = 8,
  parameter int LAT      = 2,
  parameter bit A_SIGNED = 1'b0,
  parameter bit B_SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_valid,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W:0] a_x;
  logic signed [B_W:0] b_x;
  logic [LAT-1:0]      v_d;
  logic [LAT-1:0]      v_q;
  logic [P_W-1:0]      p_d [LAT];
  logic [P_W-1:0]      p_q [LAT];

  // One extra bit lets one signed multiply cover every signedness mix.
  always_comb begin
    a_x = {A_SIGNED ? a[A_W-1] : 1'b0, a};
    b_x = {B_SIGNED ? b[B_W-1] : 1'b0, b};
    v_d[0] = in_valid;
    p_d[0] = a_x * b_x;
    for (int i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      p_d[i] = p_q[i-1];
    end
  end

  // Shift products and valid bits one stage per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        p_q[i] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      for (int i = 0; i < LAT; i++) begin
        p_q[i] <= p_d[i];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign p         = p_q[LAT-1];

endmodule

// File: rtl/bicubic_mac.sv
// Streaming multiply-accumulate over TAPS products per result,
// with rounding, saturation and a single-register output stage.
module bicubic_mac
  import bicubic_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int TAPS       = DEF_TAPS,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int FRAC       = DEF_FRAC,
  parameter int OUT_W      = DEF_OUT_W,
  parameter bit A_SIGNED   = 1'b0,
  parameter bit B_SIGNED   = 1'b1,
  parameter bit OUT_SIGNED = 1'b0
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [B_W-1:0]   s_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_sat
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = P_W + CNT_W;
  localparam int EXT_W = 64 - ACC_W;
  localparam bit PROD_SIGNED = A_SIGNED | B_SIGNED;

  logic             en;
  logic             p_valid;
  logic [P_W-1:0]   p;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic [63:0]      sum64;
  rs_t              rs;

  logic [CNT_W-1:0] tap_d, tap_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             m_valid_d, m_valid_q;
  logic [OUT_W-1:0] m_data_d, m_data_q;
  logic             m_sat_d, m_sat_q;

  // Whole pipeline stalls only when a result sits unaccepted.
  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;

  mul_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .LAT      (MUL_LAT),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED)
  ) u_mul (
    .clk       (aclk),
    .rst       (areset),
    .en        (en),
    .in_valid  (s_valid),
    .a         (s_a),
    .b         (s_b),
    .out_valid (p_valid),
    .p         (p)
  );

  // Widen the product; tap 0 starts a fresh sum.
  always_comb begin
    p_ext = {{CNT_W{PROD_SIGNED ? p[P_W-1] : 1'b0}}, p};
    sum   = (tap_q == '0) ? p_ext : acc_q + p_ext;
    sum64 = {{EXT_W{PROD_SIGNED ? sum[ACC_W-1] : 1'b0}}, sum};
    rs    = round_sat(sum64, FRAC, OUT_W, OUT_SIGNED);
  end

  // Tap counting, accumulation and result capture.
  always_comb begin
    tap_d     = tap_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sat_d   = m_sat_q;
    if (en) begin
      m_valid_d = 1'b0;
      if (p_valid) begin
        acc_d = sum;
        if (tap_q == CNT_W'(TAPS - 1)) begin
          tap_d     = '0;
          m_valid_d = 1'b1;
          m_data_d  = rs.data[OUT_W-1:0];
          m_sat_d   = rs.sat;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tap_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sat_q   <= 1'b0;
    end else begin
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sat_q   <= m_sat_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sat   = m_sat_q;

endmodule
